acc_fetch_decode: RTL and testbench

- Upstream control stage of the accumulator datapath.
- Sequences a 9-bit program from a synchronous instruction ROM with a program counter and multi-cycle FSM.
- Decodes each instruction into the accumulator's source-select/write controls, register-file and ALU controls, and resolves conditional branches on the current accumulator value.
- Start/Done handshake toward the testbench/top.

---
 rtl/acc_isa_pkg.sv | 50 +++++
 rtl/acc_pc.sv | 43 ++++
 rtl/acc_fetch_decode.sv | 161 ++++++++++++++++
 tb/tb_acc_fetch_decode.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_isa_pkg.sv
// Shared ISA definitions for the accumulator control stage: instruction
// classes, sequencer states, field positions and the decoded control bundle.
package acc_isa_pkg;

  typedef enum logic [2:0] {
    OP_LDIL  = 3'b000,
    OP_LDIH  = 3'b001,
    OP_MOVAR = 3'b010,
    OP_MOVRA = 3'b011,
    OP_ALU   = 3'b100,
    OP_BNZ   = 3'b101,
    OP_NOP   = 3'b110,
    OP_SYS   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Instruction field positions within the 9-bit word.
  localparam int CLASS_HI = 8;
  localparam int CLASS_LO = 6;
  localparam int OPND_HI  = 5;
  localparam int ALU_HI   = 5;
  localparam int ALU_LO   = 3;
  localparam int REG_HI   = 2;
  localparam int REG_LO   = 0;
  localparam int IMM_HI   = 3;
  localparam int IMM_LO   = 0;

  // Operand that turns class 111 into HALT; any other operand is a NOP.
  localparam logic [5:0] HALT_OPERAND = 6'h3F;

  // Decoded datapath controls, all zero outside the execute cycle.
  typedef struct packed {
    logic       acc_we;
    logic       from_reg;
    logic       from_alu;
    logic       from_imm;
    logic       load_hi;
    logic [3:0] imm;
    logic [2:0] reg_addr;
    logic       reg_we;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/acc_pc.sv
// Program counter: clear to zero, increment, or add a sign-extended 6-bit
// offset. Arithmetic wraps modulo 2^PW in both directions.
module acc_pc #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          rel,
  input  logic [5:0]    offset,
  output logic [PW-1:0] pc
);

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic [PW-1:0] off_ext;

  // Next PC; clear wins over branch, branch wins over increment.
  always_comb begin
    off_ext = {{(PW-6){offset[5]}}, offset};
    pc_d    = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (rel) begin
      pc_d = pc_q + off_ext;
    end else if (inc) begin
      pc_d = pc_q + PW'(1);
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/acc_fetch_decode.sv
// Fetch/decode sequencer for the accumulator datapath. Two cycles per
// instruction: FETCH presents the PC to the synchronous ROM, EXEC decodes
// the returned word, drives the datapath controls and advances the PC.
//
// Start/Done handshake: Start is a level sampled on the clock edge and is
// only acted on in IDLE or HALT; Done is high for exactly as long as the
// sequencer sits in HALT and drops the cycle after an accepted Start.
module acc_fetch_decode
  import acc_isa_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Start,
  output logic          Done,
  output logic [PW-1:0] Instr_Addr,
  input  logic [8:0]    Instr_In,
  input  logic [W-1:0]  Acc_In,
  output logic          Acc_Write_En,
  output logic          From_Reg,
  output logic          From_ALU,
  output logic          From_Imm,
  output logic          Load_Hi,
  output logic [3:0]    Imm_Out,
  output logic [2:0]    Reg_Addr,
  output logic          Reg_Write_En,
  output logic [2:0]    ALU_Op,
  output logic [CW-1:0] Instr_Count,
  output state_e        Dbg_State
);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pc_clr;
  logic          pc_inc;
  logic          pc_rel;
  logic [PW-1:0] pc;
  opcode_e       op;
  logic [5:0]    operand;
  logic          is_halt;
  logic          take_branch;
  ctrl_t         dec;
  ctrl_t         ctrl_out;

  assign op          = opcode_e'(Instr_In[CLASS_HI:CLASS_LO]);
  assign operand     = Instr_In[OPND_HI:0];
  assign is_halt     = (op == OP_SYS) && (operand == HALT_OPERAND);
  assign take_branch = (op == OP_BNZ) && (Acc_In != '0);

  acc_pc #(.PW(PW)) u_pc (
    .clk    (clk),
    .rst_n  (Reset_n),
    .clr    (pc_clr),
    .inc    (pc_inc),
    .rel    (pc_rel),
    .offset (operand),
    .pc     (pc)
  );

  // Instruction decode; only one accumulator source select is ever set.
  always_comb begin
    dec = '0;
    case (op)
      OP_LDIL: begin
        dec.acc_we   = 1'b1;
        dec.from_imm = 1'b1;
        dec.imm      = Instr_In[IMM_HI:IMM_LO];
      end
      OP_LDIH: begin
        dec.acc_we   = 1'b1;
        dec.from_imm = 1'b1;
        dec.load_hi  = 1'b1;
        dec.imm      = Instr_In[IMM_HI:IMM_LO];
      end
      OP_MOVAR: begin
        dec.acc_we   = 1'b1;
        dec.from_reg = 1'b1;
        dec.reg_addr = Instr_In[REG_HI:REG_LO];
      end
      OP_MOVRA: begin
        dec.reg_we   = 1'b1;
        dec.reg_addr = Instr_In[REG_HI:REG_LO];
      end
      OP_ALU: begin
        dec.acc_we   = 1'b1;
        dec.from_alu = 1'b1;
        dec.alu_op   = Instr_In[ALU_HI:ALU_LO];
        dec.reg_addr = Instr_In[REG_HI:REG_LO];
      end
      default: dec = '0;
    endcase
  end

  // Controls reach the datapath only in EXEC, and a reset asserted during
  // EXEC suppresses them immediately so no write lands on that edge.
  assign ctrl_out = ((state_q == ST_EXEC) && Reset_n) ? dec : '0;

  // Next-state, PC command and retired-instruction count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    pc_rel  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_d = ST_FETCH;
          pc_clr  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (take_branch) begin
            pc_rel = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Done         = (state_q == ST_HALT);
  assign Instr_Addr   = pc;
  assign Instr_Count  = cnt_q;
  assign Dbg_State    = state_q;
  assign Acc_Write_En = ctrl_out.acc_we;
  assign From_Reg     = ctrl_out.from_reg;
  assign From_ALU     = ctrl_out.from_alu;
  assign From_Imm     = ctrl_out.from_imm;
  assign Load_Hi      = ctrl_out.load_hi;
  assign Imm_Out      = ctrl_out.imm;
  assign Reg_Addr     = ctrl_out.reg_addr;
  assign Reg_Write_En = ctrl_out.reg_we;
  assign ALU_Op       = ctrl_out.alu_op;

endmodule

// File: tb/tb_acc_fetch_decode.sv
// Bench for acc_fetch_decode: synchronous ROM model, a decode table,
// hand-written multi-cycle sequences and randomized programs checked
// against an instruction-level reference model.
module tb_acc_fetch_decode;
  import acc_isa_pkg::*;

  localparam int W  = 8;
  localparam int PW = 8;
  localparam int CW = 4;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset_n;
  logic          Start;
  logic          Done;
  logic [PW-1:0] Instr_Addr;
  logic [8:0]    Instr_In;
  logic [W-1:0]  Acc_In;
  logic          Acc_Write_En, From_Reg, From_ALU, From_Imm, Load_Hi;
  logic [3:0]    Imm_Out;
  logic [2:0]    Reg_Addr;
  logic          Reg_Write_En;
  logic [2:0]    ALU_Op;
  logic [CW-1:0] Instr_Count;
  state_e        Dbg_State;

  acc_fetch_decode #(.W(W), .PW(PW), .CW(CW)) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Done         (Done),
    .Instr_Addr   (Instr_Addr),
    .Instr_In     (Instr_In),
    .Acc_In       (Acc_In),
    .Acc_Write_En (Acc_Write_En),
    .From_Reg     (From_Reg),
    .From_ALU     (From_ALU),
    .From_Imm     (From_Imm),
    .Load_Hi      (Load_Hi),
    .Imm_Out      (Imm_Out),
    .Reg_Addr     (Reg_Addr),
    .Reg_Write_En (Reg_Write_En),
    .ALU_Op       (ALU_Op),
    .Instr_Count  (Instr_Count),
    .Dbg_State    (Dbg_State)
  );

  // Synchronous instruction ROM: data appears the cycle after the address.
  logic [8:0] rom [256];
  logic [8:0] rom_q;
  always @(posedge clk) rom_q <= rom[Instr_Addr];
  assign Instr_In = rom_q;

  typedef struct packed {
    logic       we;
    logic       rsel;
    logic       asel;
    logic       isel;
    logic       hi;
    logic [3:0] imm;
    logic [2:0] ra;
    logic       rwe;
    logic [2:0] op;
  } tb_ctrl_t;

  tb_ctrl_t cur;
  assign cur = {Acc_Write_En, From_Reg, From_ALU, From_Imm, Load_Hi, Imm_Out,
                Reg_Addr, Reg_Write_En, ALU_Op};

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic tb_ctrl_t mk(input logic we, input logic rsel, input logic asel,
                                  input logic isel, input logic hi, input logic [3:0] imm,
                                  input logic [2:0] ra, input logic rwe, input logic [2:0] op);
    tb_ctrl_t c;
    c.we = we; c.rsel = rsel; c.asel = asel; c.isel = isel; c.hi = hi;
    c.imm = imm; c.ra = ra; c.rwe = rwe; c.op = op;
    return c;
  endfunction

  // Reference model: controls expected for an instruction word.
  function automatic tb_ctrl_t ref_ctrl(input logic [8:0] ins);
    case (ins[8:6])
      3'd0:    return mk(1, 0, 0, 1, 0, ins[3:0], 3'd0, 0, 3'd0);
      3'd1:    return mk(1, 0, 0, 1, 1, ins[3:0], 3'd0, 0, 3'd0);
      3'd2:    return mk(1, 1, 0, 0, 0, 4'd0, ins[2:0], 0, 3'd0);
      3'd3:    return mk(0, 0, 0, 0, 0, 4'd0, ins[2:0], 1, 3'd0);
      3'd4:    return mk(1, 0, 1, 0, 0, 4'd0, ins[2:0], 0, ins[5:3]);
      default: return '0;
    endcase
  endfunction

  // Reference model: next PC from plain integer arithmetic modulo 2^PW.
  function automatic logic [PW-1:0] ref_next_pc(input logic [PW-1:0] pc,
                                                input logic [8:0] ins, input logic [W-1:0] acc);
    int off;
    int nxt;
    off = int'(ins[5:0]);
    if (off >= 32) off = off - 64;
    if (ins[8:6] == 3'd5 && acc != 0) nxt = int'(pc) + off;
    else nxt = int'(pc) + 1;
    nxt = nxt & ((1 << PW) - 1);
    return PW'(nxt);
  endfunction

  function automatic int sat_cnt(input int n);
    return (n >= (1 << CW) - 1) ? (1 << CW) - 1 : n;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    Start   = 1'b0;
    Acc_In  = '0;
    tick();
    tick();
    Reset_n = 1'b1;
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 9'h180;
  endtask

  // Leaves the bench in the first FETCH cycle (cycle 1 after Start).
  task automatic start_prog();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
  endtask

  typedef struct {
    int            addr;
    logic [8:0]    ins;
    logic [W-1:0]  acc;
    tb_ctrl_t      exp;
    logic [PW-1:0] exp_next;
  } vec_t;

  vec_t vecs[14];

  logic [PW-1:0] m_pc;
  int            m_cnt;
  logic [8:0]    ins;
  bit            halted;

  initial begin
    Reset_n = 1'b0;
    Start   = 1'b0;
    Acc_In  = '0;
    fill_nop();

    vecs[0]  = '{0,   9'h005, 8'h00, mk(1,0,0,1,0,4'h5,3'd0,0,3'd0), 8'd1};
    vecs[1]  = '{0,   9'h04A, 8'h00, mk(1,0,0,1,1,4'hA,3'd0,0,3'd0), 8'd1};
    vecs[2]  = '{1,   9'h03F, 8'h00, mk(1,0,0,1,0,4'hF,3'd0,0,3'd0), 8'd2};
    vecs[3]  = '{2,   9'h086, 8'h00, mk(1,1,0,0,0,4'h0,3'd6,0,3'd0), 8'd3};
    vecs[4]  = '{0,   9'h0C3, 8'h00, mk(0,0,0,0,0,4'h0,3'd3,1,3'd0), 8'd1};
    vecs[5]  = '{0,   9'h113, 8'h00, mk(1,0,1,0,0,4'h0,3'd3,0,3'd2), 8'd1};
    vecs[6]  = '{3,   9'h138, 8'h00, mk(1,0,1,0,0,4'h0,3'd0,0,3'd7), 8'd4};
    vecs[7]  = '{4,   9'h17E, 8'h00, '0, 8'd5};
    vecs[8]  = '{4,   9'h17E, 8'h01, '0, 8'd2};
    vecs[9]  = '{255, 9'h141, 8'h01, '0, 8'd0};
    vecs[10] = '{10,  9'h140, 8'h03, '0, 8'd10};
    vecs[11] = '{5,   9'h1AB, 8'hFF, '0, 8'd6};
    vecs[12] = '{6,   9'h1FE, 8'h00, '0, 8'd7};
    vecs[13] = '{3,   9'h1FF, 8'h00, '0, 8'd3};

    // Reset state
    do_reset();
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_addr", 32'(Instr_Addr), 32'd0);
    chk("rst_ctrl", 32'(cur), 32'd0);
    chk("rst_count", 32'(Instr_Count), 32'd0);
    chk("rst_state", 32'(Dbg_State), 32'(ST_IDLE));

    // Decode table: target instruction placed after a run of NOPs
    foreach (vecs[v]) begin
      do_reset();
      fill_nop();
      rom[vecs[v].addr] = vecs[v].ins;
      start_prog();
      for (int k = 0; k < 1 + 2 * vecs[v].addr; k++) tick();
      Acc_In = vecs[v].acc;
      #1;
      chk($sformatf("vec%0d_ctrl", v), 32'(cur), 32'(vecs[v].exp));
      tick();
      chk($sformatf("vec%0d_next_addr", v), 32'(Instr_Addr), 32'(vecs[v].exp_next));
      chk($sformatf("vec%0d_count", v), 32'(Instr_Count), 32'(sat_cnt(vecs[v].addr + 1)));
    end

    // LDIL 5, LDIH A, HALT; then restart from HALT
    do_reset();
    fill_nop();
    rom[0] = 9'h005; rom[1] = 9'h04A; rom[2] = 9'h1FF;
    start_prog();                     // cycle 1
    tick();                           // cycle 2
    chk("seq_c2_imm", 32'(cur), 32'(mk(1,0,0,1,0,4'h5,3'd0,0,3'd0)));
    tick(); tick();                   // cycle 4
    chk("seq_c4_imm", 32'(cur), 32'(mk(1,0,0,1,1,4'hA,3'd0,0,3'd0)));
    tick(); tick();                   // cycle 6
    chk("seq_c6_done", 32'(Done), 32'd0);
    chk("seq_c6_ctrl", 32'(cur), 32'd0);
    tick();                           // cycle 7
    chk("seq_c7_done", 32'(Done), 32'd1);
    chk("seq_c7_count", 32'(Instr_Count), 32'd3);
    chk("seq_c7_addr", 32'(Instr_Addr), 32'd2);
    tick();
    chk("seq_halt_hold_done", 32'(Done), 32'd1);
    chk("seq_halt_hold_addr", 32'(Instr_Addr), 32'd2);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("restart_done", 32'(Done), 32'd0);
    chk("restart_addr", 32'(Instr_Addr), 32'd0);
    chk("restart_count", 32'(Instr_Count), 32'd0);
    chk("restart_state", 32'(Dbg_State), 32'(ST_FETCH));

    // Start during FETCH and EXEC is ignored
    do_reset();
    fill_nop();
    start_prog();
    Start = 1'b1;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    chk("start_ignored_addr", 32'(Instr_Addr), 32'd1);
    chk("start_ignored_count", 32'(Instr_Count), 32'd1);

    // Counter saturates at all-ones
    do_reset();
    fill_nop();
    start_prog();
    for (int k = 0; k < 40; k++) tick();
    chk("count_saturated", 32'(Instr_Count), 32'(sat_cnt(20)));

    // Reset asserted during EXEC of LDIL
    do_reset();
    fill_nop();
    rom[0] = 9'h00C;
    start_prog();
    tick();
    chk("pre_rst_exec_we", 32'(Acc_Write_En), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("rst_exec_we", 32'(Acc_Write_En), 32'd0);
    chk("rst_exec_ctrl", 32'(cur), 32'd0);
    tick();
    chk("rst_exec_state", 32'(Dbg_State), 32'(ST_IDLE));
    chk("rst_exec_addr", 32'(Instr_Addr), 32'd0);
    chk("rst_exec_ctrl_after", 32'(cur), 32'd0);
    chk("rst_exec_done", 32'(Done), 32'd0);
    chk("rst_exec_count", 32'(Instr_Count), 32'd0);
    Reset_n = 1'b1;

    // Randomized programs against the instruction-level model
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int i = 0; i < 256; i++)
        rom[i] = ($urandom_range(0, 29) == 0) ? 9'h1FF : 9'($urandom);
      start_prog();
      m_pc   = '0;
      m_cnt  = 0;
      halted = 1'b0;
      for (int i = 0; i < 120 && !halted; i++) begin
        Start = ($urandom_range(0, 3) == 0);
        #1;
        chk("rnd_fetch_addr", 32'(Instr_Addr), 32'(m_pc));
        chk("rnd_fetch_ctrl", 32'(cur), 32'd0);
        chk("rnd_fetch_count", 32'(Instr_Count), 32'(m_cnt));
        chk("rnd_fetch_done", 32'(Done), 32'd0);
        tick();
        Start  = ($urandom_range(0, 3) == 0);
        Acc_In = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 255));
        #1;
        ins = rom[m_pc];
        chk("rnd_exec_ctrl", 32'(cur), 32'(ref_ctrl(ins)));
        m_cnt = sat_cnt(m_cnt + 1);
        if (ins == 9'h1FF) halted = 1'b1;
        else m_pc = ref_next_pc(m_pc, ins, Acc_In);
        tick();
      end
      Start = 1'b0;
      #1;
      if (halted) begin
        chk("rnd_halt_done", 32'(Done), 32'd1);
        chk("rnd_halt_addr", 32'(Instr_Addr), 32'(m_pc));
        chk("rnd_halt_count", 32'(Instr_Count), 32'(m_cnt));
      end
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
